// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
//   Shared encodings for the RV32M multiply/divide unit: opcode/funct7/funct3
//   values, the 3-bit FSM state type, widths, and a small absolute-value helper.
package ex_muldiv_pkg;

  localparam int XLEN             = 32;
  localparam int MULDIV_CNT_WIDTH = 5;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_DONE = 3'd3,
    ST_HELD = 3'd4
  } muldiv_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [XLEN-1:0] abs_xlen(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// ex_div_iter
//   Radix-2 restoring divider core on unsigned magnitudes.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     start_i        load dividend/divisor and clear the counter
//     abort_i        drop the operation in progress (wins over start_i)
//     dividend_i     unsigned dividend
//     divisor_i      unsigned divisor (non-zero; zero is handled by the caller)
//     quotient_o     quotient after the step performed this cycle
//     remainder_o    remainder after the step performed this cycle
//     done_o         high during the final (32nd) step; quotient_o/remainder_o
//                    are then the finished results
module ex_div_iter
  import ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  logic [XLEN-1:0]             rem_q, rem_d;
  logic [XLEN-1:0]             quot_q, quot_d;
  logic [XLEN-1:0]             dvsr_q, dvsr_d;
  logic [MULDIV_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                        active_q, active_d;

  logic [XLEN:0]   rem_sh;
  logic            take;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quot;

  // One restoring step: shift {rem,quot} left, subtract when it fits.
  // rem stays below dvsr, so the shifted value needs one extra bit but the
  // difference always fits back into XLEN bits.
  always_comb begin
    rem_sh    = {rem_q, quot_q[XLEN-1]};
    take      = (rem_sh >= {1'b0, dvsr_q});
    step_rem  = take ? (rem_sh[XLEN-1:0] - dvsr_q) : rem_sh[XLEN-1:0];
    step_quot = {quot_q[XLEN-2:0], take};
  end

  assign quotient_o  = step_quot;
  assign remainder_o = step_rem;
  assign done_o      = active_q && (cnt_q == '1);

  always_comb begin
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (abort_i) begin
      rem_d    = '0;
      quot_d   = '0;
      dvsr_d   = '0;
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      rem_d    = '0;
      quot_d   = dividend_i;
      dvsr_d   = divisor_i;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      rem_d  = step_rem;
      quot_d = step_quot;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv
//   RV32M multiply/divide unit in the EX stage. Multiplies take 2 cycles,
//   divide special cases 1 cycle, normal divides 33 cycles (32 restoring
//   steps in ex_div_iter). While working it requests a pipeline hold so the
//   ID/EX register keeps presenting the instruction.
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     ex_muldiv_opcode_i/funct3_i/funct7_i/rd_i  decoded instruction fields
//     ex_muldiv_rs1_data_i/rs2_data_i            operands
//     ex_muldiv_flush_i          abort (wins over start and ext hold)
//     ex_muldiv_ext_hold_i       hold from other sources
//     ex_muldiv_hold_req_o       hold request (start cycle, MUL, DIV)
//     ex_muldiv_busy_o           state != IDLE
//     ex_muldiv_we_o/rd_o/result_o  one-cycle write-back, nonzero only in DONE
//   Handshake: the instruction is "offered" whenever opcode/funct7 decode as
//   M-extension and the unit is IDLE; it is accepted that same cycle, and
//   hold_req_o keeps the offer stable until the DONE cycle, where we_o is the
//   single completion strobe and hold_req_o drops so the pipeline advances.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      ex_muldiv_opcode_i,
  input  logic [2:0]      ex_muldiv_funct3_i,
  input  logic [6:0]      ex_muldiv_funct7_i,
  input  logic [4:0]      ex_muldiv_rd_i,
  input  logic [XLEN-1:0] ex_muldiv_rs1_data_i,
  input  logic [XLEN-1:0] ex_muldiv_rs2_data_i,
  input  logic            ex_muldiv_flush_i,
  input  logic            ex_muldiv_ext_hold_i,
  output logic            ex_muldiv_hold_req_o,
  output logic            ex_muldiv_busy_o,
  output logic            ex_muldiv_we_o,
  output logic [4:0]      ex_muldiv_rd_o,
  output logic [XLEN-1:0] ex_muldiv_result_o
);

  muldiv_state_e   state_q, state_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_lat_q, rd_lat_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            start;
  logic            signed_div;
  logic            div_by_zero;
  logic            div_ovf;
  logic            div_special;
  logic [XLEN-1:0] special_result;
  logic            div_start;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic [XLEN-1:0] div_quot;
  logic [XLEN-1:0] div_rem;
  logic            div_done;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic            mul_a_sign;
  logic            mul_b_sign;
  logic [63:0]     mul_a;
  logic [63:0]     mul_b;
  logic [63:0]     prod;

  assign start = (ex_muldiv_opcode_i == OPCODE_OP) && (ex_muldiv_funct7_i == FUNCT7_MULDIV)
              && (state_q == ST_IDLE) && !ex_muldiv_flush_i;

  // funct3[0]=0 selects the signed divide/remainder forms.
  assign signed_div  = !ex_muldiv_funct3_i[0];
  assign div_by_zero = (ex_muldiv_rs2_data_i == '0);
  assign div_ovf     = signed_div && (ex_muldiv_rs1_data_i == 32'h8000_0000)
                    && (ex_muldiv_rs2_data_i == 32'hFFFF_FFFF);
  assign div_special = div_by_zero || div_ovf;

  always_comb begin
    special_result = '0;
    if (div_by_zero) begin
      special_result = ex_muldiv_funct3_i[1] ? ex_muldiv_rs1_data_i : '1;
    end else if (div_ovf) begin
      special_result = ex_muldiv_funct3_i[1] ? '0 : 32'h8000_0000;
    end
  end

  assign div_start    = start && ex_muldiv_funct3_i[2] && !div_special;
  assign div_dividend = signed_div ? abs_xlen(ex_muldiv_rs1_data_i) : ex_muldiv_rs1_data_i;
  assign div_divisor  = signed_div ? abs_xlen(ex_muldiv_rs2_data_i) : ex_muldiv_rs2_data_i;

  ex_div_iter u_div_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .abort_i     (ex_muldiv_flush_i),
    .dividend_i  (div_dividend),
    .divisor_i   (div_divisor),
    .quotient_o  (div_quot),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  assign quot_fix = neg_quot_q ? (~div_quot + 1'b1) : div_quot;
  assign rem_fix  = neg_rem_q  ? (~div_rem + 1'b1)  : div_rem;

  // 33-bit extended operands; the low 64 bits of their product are exact, so
  // the multiply is done on 64-bit sign/zero-extended copies.
  assign mul_a_sign = ((funct3_q == F3_MULH) || (funct3_q == F3_MULHSU)) && op_a_q[XLEN-1];
  assign mul_b_sign = (funct3_q == F3_MULH) && op_b_q[XLEN-1];
  assign mul_a      = {{32{mul_a_sign}}, op_a_q};
  assign mul_b      = {{32{mul_b_sign}}, op_b_q};
  assign prod       = mul_a * mul_b;

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    funct3_d   = funct3_q;
    rd_lat_d   = rd_lat_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    we_d       = 1'b0;
    rd_d       = '0;
    result_d   = '0;
    if (ex_muldiv_flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_a_d   = ex_muldiv_rs1_data_i;
            op_b_d   = ex_muldiv_rs2_data_i;
            funct3_d = ex_muldiv_funct3_i;
            rd_lat_d = ex_muldiv_rd_i;
            if (!ex_muldiv_funct3_i[2]) begin
              state_d = ST_MUL;
            end else if (div_special) begin
              we_d     = 1'b1;
              rd_d     = ex_muldiv_rd_i;
              result_d = special_result;
              state_d  = ST_DONE;
            end else begin
              neg_quot_d = signed_div && (ex_muldiv_rs1_data_i[XLEN-1] ^ ex_muldiv_rs2_data_i[XLEN-1]);
              neg_rem_d  = signed_div && ex_muldiv_rs1_data_i[XLEN-1];
              state_d    = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          we_d     = 1'b1;
          rd_d     = rd_lat_q;
          result_d = (funct3_q == F3_MUL) ? prod[31:0] : prod[63:32];
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          if (div_done) begin
            we_d     = 1'b1;
            rd_d     = rd_lat_q;
            result_d = funct3_q[1] ? rem_fix : quot_fix;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: state_d = ex_muldiv_ext_hold_i ? ST_HELD : ST_IDLE;
        // The finished instruction is still in ID/EX here; no restart.
        ST_HELD: state_d = ex_muldiv_ext_hold_i ? ST_HELD : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      funct3_q   <= '0;
      rd_lat_q   <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      funct3_q   <= funct3_d;
      rd_lat_q   <= rd_lat_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
    end
  end

  assign ex_muldiv_hold_req_o = !ex_muldiv_flush_i
                             && (start || (state_q == ST_MUL) || (state_q == ST_DIV));
  assign ex_muldiv_busy_o     = (state_q != ST_IDLE);
  // A flush in the DONE cycle still suppresses the write strobe.
  assign ex_muldiv_we_o       = we_q && !ex_muldiv_flush_i;
  assign ex_muldiv_rd_o       = rd_q;
  assign ex_muldiv_result_o   = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        ext_hold;
  logic        hold_req;
  logic        busy;
  logic        we;
  logic [4:0]  rd_o;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ex_muldiv_opcode_i   (opcode),
    .ex_muldiv_funct3_i   (funct3),
    .ex_muldiv_funct7_i   (funct7),
    .ex_muldiv_rd_i       (rd),
    .ex_muldiv_rs1_data_i (rs1),
    .ex_muldiv_rs2_data_i (rs2),
    .ex_muldiv_flush_i    (flush),
    .ex_muldiv_ext_hold_i (ext_hold),
    .ex_muldiv_hold_req_o (hold_req),
    .ex_muldiv_busy_o     (busy),
    .ex_muldiv_we_o       (we),
    .ex_muldiv_rd_o       (rd_o),
    .ex_muldiv_result_o   (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M results from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa = $signed(a);
    longint      sb = $signed(b);
    longint      ua = {32'd0, a};
    longint      ub = {32'd0, b};
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic drive_nop();
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; rd = 5'd0; rs1 = 32'd0; rs2 = 32'd0;
  endtask

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
    opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = f3; rd = r; rs1 = a; rs2 = b;
  endtask

  // Present one M instruction, keep it while hold is requested, check the
  // write-back and its timing, then let the pipeline advance.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input string tag);
    logic [31:0] exp_res = ref_result(f3, a, b);
    int          exp_lat = ref_latency(f3, a, b);
    int          lat = 0;
    int          hold_cnt = 1;
    @(negedge clk);
    drive_m(f3, a, b, r);
    #1;
    check({tag, "_hold_start"}, {31'd0, hold_req}, 32'd1);
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd0);
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk); #1;
      if (we) begin
        lat = c;
        check({tag, "_result"}, result, exp_res);
        check({tag, "_rd"}, {27'd0, rd_o}, {27'd0, r});
        check({tag, "_hold_done"}, {31'd0, hold_req}, 32'd0);
      end else if (hold_req) begin
        hold_cnt++;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_hold_cycles"}, hold_cnt, exp_lat);
    @(negedge clk);
    drive_nop();
    #1;
    check({tag, "_after_we"}, {31'd0, we}, 32'd0);
    check({tag, "_after_result"}, result, 32'd0);
    check({tag, "_after_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    // Reset
    rst_n = 1'b0; flush = 1'b0; ext_hold = 1'b0;
    drive_nop();
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_we", {31'd0, we}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd", {27'd0, rd_o}, 32'd0);
    check("reset_hold", {31'd0, hold_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiplies
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, "mulhsu");

    // Normal divides
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, "rem_neg");
    run_op(3'd5, 32'd100, 32'd7, 5'd11, "divu");
    run_op(3'd7, 32'd100, 32'd7, 5'd12, "remu");

    // Divide special cases
    run_op(3'd5, 32'd5, 32'd0, 5'd13, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, 5'd14, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, "rem_ovf");
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, "divu_noovf");

    // Flush at divide iteration 10
    @(negedge clk);
    drive_m(3'd4, 32'd1000, 32'd3, 5'd18);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    drive_nop();
    #1;
    check("flush_hold", {31'd0, hold_req}, 32'd0);
    check("flush_we", {31'd0, we}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (we) pulses++;
    end
    check("flush_no_we", pulses, 0);
    run_op(3'd4, 32'd1000, 32'd3, 5'd18, "div_after_flush");

    // External hold during DONE
    @(negedge clk);
    drive_m(3'd0, 32'd12, 32'd13, 5'd19);
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ext_hold = (c >= 2 && c <= 4);
      if (c >= 6) drive_nop();
      #1;
      if (we) pulses++;
      if (c == 2) check("hold_result", result, ref_result(3'd0, 32'd12, 32'd13));
      if (c == 3) check("hold_held_busy", {31'd0, busy}, 32'd1);
      if (c == 5) check("hold_held_hreq", {31'd0, hold_req}, 32'd0);
      if (c == 6) check("hold_idle", {31'd0, busy}, 32'd0);
    end
    check("hold_one_pulse", pulses, 1);

    // Reset in the middle of a divide
    @(negedge clk);
    drive_m(3'd5, 32'd100, 32'd7, 5'd20);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    drive_nop();
    @(negedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_we", {31'd0, we}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd", {27'd0, rd_o}, 32'd0);
    check("midrst_hold", {31'd0, hold_req}, 32'd0);
    rst_n = 1'b1;

    // Non-M opcode (ADD) never starts the unit
    @(negedge clk);
    opcode = 7'b0110011; funct7 = 7'd0; funct3 = 3'd0; rd = 5'd3;
    rs1 = 32'd4; rs2 = 32'd5;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (busy || hold_req || we) pulses++;
    end
    check("add_ignored", pulses, 0);
    drive_nop();

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: begin
          rb = 32'hFFFF_FFFF;
          if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000;
        end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rf3, ra, rb, 5'($urandom_range(1, 31)), $sformatf("rand%0d_f%0d", i, rf3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
